// File: rtl/wb_block_writer.sv
// wb_block_writer
//   Accepts 8x8 reconstructed-luma write-back blocks, buffers them in a small
//   FIFO and writes each block to the reference-frame line memory one row
//   per accepted memory cycle. It also reports idle, frame-complete and
//   out-of-range-block events.
//
//   State | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | FIFO empty, no memory write in flight
//   WRITE | presenting row `row` of the FIFO head to the line memory
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   wb_en_in        block valid; wb_data_in = {x_idx, y_idx, pixels}
//   wb_ack_out      block accepted this cycle (combinational)
//   mem_wr_en_out   row write request; mem_addr_out / mem_wdata_out row
//   mem_ready_in    memory accepts the row this cycle
//   idle_out        FIFO empty and no write in flight
//   frame_done_out  1-cycle pulse after the last block of a picture
//   err_out         sticky, an out-of-range block was received
module wb_block_writer #(
   parameter int BLOCK_SIZE = 8,
   parameter int BIT_DEPTH  = 8,
   parameter int IDX_WIDTH  = 9,
   parameter int IMG_WIDTH  = 1920,
   parameter int IMG_HEIGHT = 1080,
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_WIDTH = 18
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic                                                 wb_en_in,
   input  logic [2*IDX_WIDTH+BIT_DEPTH*BLOCK_SIZE*BLOCK_SIZE-1:0] wb_data_in,
   output logic                                                 wb_ack_out,
   output logic                                                 mem_wr_en_out,
   output logic [ADDR_WIDTH-1:0]                                mem_addr_out,
   output logic [BIT_DEPTH*BLOCK_SIZE-1:0]                      mem_wdata_out,
   input  logic                                                 mem_ready_in,
   output logic                                                 idle_out,
   output logic                                                 frame_done_out,
   output logic                                                 err_out
);

   localparam int PIX_W  = BIT_DEPTH*BLOCK_SIZE*BLOCK_SIZE;
   localparam int DATA_W = 2*IDX_WIDTH + PIX_W;
   localparam int ROW_W  = BIT_DEPTH*BLOCK_SIZE;
   localparam int BLK_W  = IMG_WIDTH/BLOCK_SIZE;
   localparam int BLK_H  = IMG_HEIGHT/BLOCK_SIZE;
   localparam int TOTAL  = BLK_W*BLK_H;
   localparam int ROW_CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
   localparam int BCNT_W = $clog2(TOTAL+1);
   // wide enough that y*BLOCK_SIZE*BLK_W cannot wrap before truncation
   localparam int AW     = ADDR_WIDTH + IDX_WIDTH;

   localparam logic [CNT_W-1:0]     DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [ROW_CW-1:0]    LAST_ROW = ROW_CW'(BLOCK_SIZE-1);
   localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(FIFO_DEPTH-1);
   localparam logic [BCNT_W-1:0]    LAST_BLK = BCNT_W'(TOTAL-1);
   localparam logic [IDX_WIDTH-1:0] BLK_W_C  = IDX_WIDTH'(BLK_W);
   localparam logic [IDX_WIDTH-1:0] BLK_H_C  = IDX_WIDTH'(BLK_H);

   typedef enum logic {S_IDLE, S_WRITE} state_t;

   state_t                state;
   logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_nxt;
   logic [ROW_CW-1:0]     row;
   logic [BCNT_W-1:0]     blk_cnt;
   logic [DATA_W-1:0]     head;
   logic [IDX_WIDTH-1:0]  in_x, in_y, head_x, head_y;
   logic                  in_range, push, pop, row_done;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign in_x     = wb_data_in[DATA_W-1 -: IDX_WIDTH];
   assign in_y     = wb_data_in[PIX_W +: IDX_WIDTH];
   assign in_range = (in_x < BLK_W_C) && (in_y < BLK_H_C);

   // No bypass when full: ack looks only at the registered count.
   assign wb_ack_out = wb_en_in && (count < DEPTH_C) && !reset;
   assign push       = wb_ack_out && in_range;
   assign row_done   = (state == S_WRITE) && mem_ready_in;
   assign pop        = row_done && (row == LAST_ROW);
   assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);

   assign head   = fifo_mem[rd_ptr];
   assign head_x = head[DATA_W-1 -: IDX_WIDTH];
   assign head_y = head[PIX_W +: IDX_WIDTH];

   assign idle_out      = (state == S_IDLE) && (count == '0);
   assign mem_wr_en_out = (state == S_WRITE);

   // Driven only from registers, so address and data stay put during a stall.
   always_comb begin
      mem_addr_out  = '0;
      mem_wdata_out = '0;
      if (state == S_WRITE) begin
         mem_addr_out  = ADDR_WIDTH'(((AW'(head_y) * AW'(BLOCK_SIZE)) + AW'(row))
                                     * AW'(BLK_W) + AW'(head_x));
         mem_wdata_out = head[row*ROW_W +: ROW_W];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= wb_data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         row            <= '0;
         blk_cnt        <= '0;
         frame_done_out <= 1'b0;
         err_out        <= 1'b0;
      end else begin
         frame_done_out <= 1'b0;
         if (wb_ack_out && !in_range) begin
            err_out <= 1'b1;
         end
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (row_done) begin
            if (pop) begin
               row    <= '0;
               rd_ptr <= ptr_inc(rd_ptr);
               if (blk_cnt == LAST_BLK) begin
                  blk_cnt        <= '0;
                  frame_done_out <= 1'b1;
               end else begin
                  blk_cnt <= blk_cnt + 1'b1;
               end
            end else begin
               row <= row + 1'b1;
            end
         end
         count <= count_nxt;
         state <= (count_nxt != '0) ? S_WRITE : S_IDLE;
      end
   end

endmodule

// File: tb/tb_wb_block_writer.sv
// Testbench for wb_block_writer. Two instances: the default 1920x1080
// picture (dut0) and a 32x16 picture (dut1) for frame-completion checks.
module tb_wb_block_writer;

   localparam int DW = 2*9 + 512;

   typedef struct packed {
      logic [17:0] addr;
      logic [63:0] data;
      logic        last;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_ready;
   logic          en    [2];
   logic [DW-1:0] wdat  [2];
   logic          ack   [2];
   logic          wr_en [2];
   logic [17:0]   maddr [2];
   logic [63:0]   mwd   [2];
   logic          idle  [2];
   logic          fd    [2];
   logic          err   [2];

   always #5 clk = ~clk;

   wb_block_writer dut0 (
      .clk(clk), .reset(reset), .wb_en_in(en[0]), .wb_data_in(wdat[0]),
      .wb_ack_out(ack[0]), .mem_wr_en_out(wr_en[0]), .mem_addr_out(maddr[0]),
      .mem_wdata_out(mwd[0]), .mem_ready_in(mem_ready), .idle_out(idle[0]),
      .frame_done_out(fd[0]), .err_out(err[0]));

   wb_block_writer #(.IMG_WIDTH(32), .IMG_HEIGHT(16)) dut1 (
      .clk(clk), .reset(reset), .wb_en_in(en[1]), .wb_data_in(wdat[1]),
      .wb_ack_out(ack[1]), .mem_wr_en_out(wr_en[1]), .mem_addr_out(maddr[1]),
      .mem_wdata_out(mwd[1]), .mem_ready_in(mem_ready), .idle_out(idle[1]),
      .frame_done_out(fd[1]), .err_out(err[1]));

   int tests = 0;
   int fails = 0;

   // reference model: expected row writes per instance, blocks held, frame count
   wr_t   q0[$];
   wr_t   q1[$];
   int    occ   [2];
   int    blk   [2];
   int    nwr   [2];
   int    nfd   [2];
   logic  err_m [2];
   logic  fd_m  [2];
   logic  stall_p [2];
   logic [17:0] paddr [2];
   logic [63:0] pdata [2];
   bit    mon_on = 0;
   int    rmode = 0;
   logic  rval = 1'b0;

   function automatic int bw(int d); return (d == 0) ? 240 : 4; endfunction
   function automatic int bh(int d); return (d == 0) ? 135 : 2; endfunction
   function automatic int qsize(int d); return (d == 0) ? q0.size() : q1.size(); endfunction
   function automatic wr_t qfront(int d); return (d == 0) ? q0[0] : q1[0]; endfunction

   task automatic qpop(int d);
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
   endtask

   task automatic qpush(int d, wr_t e);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(int d);
      logic exp_ack;
      bit   has;
      wr_t  e;
      int   x, y;
      logic [511:0] pix;
      has     = (qsize(d) != 0);
      exp_ack = en[d] && (occ[d] < 2) && !reset;
      chk($sformatf("d%0d_ack", d), ack[d], exp_ack);
      chk($sformatf("d%0d_wr_en", d), wr_en[d], has);
      chk($sformatf("d%0d_idle", d), idle[d], (occ[d] == 0));
      chk($sformatf("d%0d_err", d), err[d], err_m[d]);
      chk($sformatf("d%0d_frame_done", d), fd[d], fd_m[d]);
      if (has) begin
         e = qfront(d);
         chk($sformatf("d%0d_addr", d), maddr[d], e.addr);
         chk($sformatf("d%0d_wdata", d), mwd[d], e.data);
      end else begin
         chk($sformatf("d%0d_addr_zero", d), maddr[d], 0);
         chk($sformatf("d%0d_wdata_zero", d), mwd[d], 0);
      end
      if (stall_p[d] && wr_en[d]) begin
         chk($sformatf("d%0d_stall_addr", d), maddr[d], paddr[d]);
         chk($sformatf("d%0d_stall_wdata", d), mwd[d], pdata[d]);
      end
      if (fd[d] === 1'b1) nfd[d]++;
      fd_m[d] = 1'b0;
      if (reset) begin
         if (d == 0) q0.delete(); else q1.delete();
         occ[d] = 0; blk[d] = 0; err_m[d] = 1'b0; stall_p[d] = 1'b0;
      end else begin
         stall_p[d] = wr_en[d] && !mem_ready;
         paddr[d]   = maddr[d];
         pdata[d]   = mwd[d];
         if (has && mem_ready) begin
            e = qfront(d);
            qpop(d);
            nwr[d]++;
            if (e.last) begin
               occ[d]--;
               blk[d]++;
               if (blk[d] == bw(d)*bh(d)) begin
                  blk[d] = 0;
                  fd_m[d] = 1'b1;
               end
            end
         end
         if (exp_ack) begin
            x   = int'(wdat[d][DW-1 -: 9]);
            y   = int'(wdat[d][512 +: 9]);
            pix = wdat[d][511:0];
            if (x < bw(d) && y < bh(d)) begin
               for (int r = 0; r < 8; r++) begin
                  e.addr = 18'((y*8 + r)*bw(d) + x);
                  e.data = pix[r*64 +: 64];
                  e.last = (r == 7);
                  qpush(d, e);
               end
               occ[d]++;
            end else begin
               err_m[d] = 1'b1;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         model_step(0);
         model_step(1);
      end
   end

   // memory-ready driver: 0 = follow rval, 1 = random, 2 = toggle
   initial begin
      mem_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rmode == 1)      mem_ready = 1'($urandom_range(0, 1));
         else if (rmode == 2) mem_ready = ~mem_ready;
         else                 mem_ready = rval;
      end
   end

   function automatic logic [511:0] rand_pix();
      logic [511:0] p;
      for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_blk(int d, int x, int y, logic [511:0] pix);
      en[d]   = 1'b1;
      wdat[d] = {9'(x), 9'(y), pix};
   endtask

   task automatic wait_ack(int d, output int n);
      n = 0;
      @(negedge clk);
      while (ack[d] !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("d%0d_ack_wait", d), ack[d], 1'b1);
      tick();
   endtask

   task automatic send(int d, int x, int y, logic [511:0] pix);
      int n;
      set_blk(d, x, y, pix);
      wait_ack(d, n);
      en[d] = 1'b0;
   endtask

   task automatic drain(int d);
      int n = 0;
      while ((qsize(d) != 0 || occ[d] != 0) && n < 3000) begin
         tick();
         n++;
      end
      chk($sformatf("d%0d_drain", d), qsize(d), 0);
   endtask

   initial begin
      int n, w0;
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         en[d] = 1'b0; wdat[d] = '0; occ[d] = 0; blk[d] = 0; nwr[d] = 0; nfd[d] = 0;
         err_m[d] = 1'b0; fd_m[d] = 1'b0; stall_p[d] = 1'b0; paddr[d] = '0; pdata[d] = '0;
      end
      repeat (3) tick();
      mon_on = 1;

      // reset state
      @(negedge clk);
      chk("rst_idle", idle[0], 1'b1);
      chk("rst_wr_en", wr_en[0], 1'b0);
      chk("rst_addr", maddr[0], 0);
      chk("rst_wdata", mwd[0], 0);
      chk("rst_err", err[0], 1'b0);
      chk("rst_fd", fd[0], 1'b0);
      tick();
      reset = 1'b0;

      // single block x=2,y=1 with memory always ready
      rval = 1'b1;
      tick();
      w0 = nwr[0];
      send(0, 2, 1, rand_pix());
      drain(0);
      @(negedge clk);
      chk("t1_idle_after", idle[0], 1'b1);
      chk("t1_writes", nwr[0] - w0, 8);
      tick();

      // three blocks against a stalled memory
      rval = 1'b0;
      tick();
      w0 = nwr[0];
      set_blk(0, 0, 0, rand_pix());
      wait_ack(0, n);
      set_blk(0, 1, 0, rand_pix());
      wait_ack(0, n);
      set_blk(0, 2, 0, rand_pix());
      repeat (3) begin
         @(negedge clk);
         chk("t2_third_ack_low", ack[0], 1'b0);
         tick();
      end
      rval = 1'b1;
      wait_ack(0, n);
      chk("t2_ack_latency", n, 8);
      en[0] = 1'b0;
      drain(0);
      chk("t2_writes", nwr[0] - w0, 24);

      // toggling ready
      rmode = 2;
      w0 = nwr[0];
      send(0, 7, 9, rand_pix());
      drain(0);
      chk("t3_writes", nwr[0] - w0, 8);
      rmode = 0;
      tick();

      // out-of-range block
      w0 = nwr[0];
      send(0, 240, 0, rand_pix());
      @(negedge clk);
      chk("t4_err_set", err[0], 1'b1);
      chk("t4_no_write", wr_en[0], 1'b0);
      repeat (5) tick();
      @(negedge clk);
      chk("t4_err_sticky", err[0], 1'b1);
      chk("t4_writes", nwr[0] - w0, 0);
      tick();

      // 32x16 picture: 8 blocks make a frame, one rejected block mixed in
      rmode = 1;
      for (int y = 0; y < 2; y++) begin
         for (int x = 0; x < 4; x++) begin
            send(1, x, y, rand_pix());
            if (x == 2 && y == 0) send(1, 4, 0, rand_pix());
         end
      end
      drain(1);
      repeat (3) tick();
      chk("t5_one_pulse", nfd[1], 1);
      chk("t5_err", err[1], 1'b1);
      send(1, 1, 1, rand_pix());
      drain(1);
      repeat (3) tick();
      chk("t5_ninth_no_pulse", nfd[1], 1);
      rmode = 0;
      rval = 1'b1;
      tick();

      // reset in the middle of a block
      w0 = nwr[0];
      send(0, 5, 3, rand_pix());
      repeat (3) tick();
      reset = 1'b1;
      set_blk(0, 6, 3, rand_pix());
      @(negedge clk);
      chk("t6_ack_in_reset", ack[0], 1'b0);
      tick();
      @(negedge clk);
      chk("t6_wr_en_after", wr_en[0], 1'b0);
      chk("t6_idle_after", idle[0], 1'b1);
      chk("t6_err_cleared", err[0], 1'b0);
      tick();
      reset = 1'b0;
      wait_ack(0, n);
      en[0] = 1'b0;
      drain(0);
      chk("t6_writes", nwr[0] - w0, 11);

      // random traffic with random memory backpressure
      rmode = 1;
      for (int i = 0; i < 30; i++) begin
         send(0, int'($urandom_range(0, 245)), int'($urandom_range(0, 136)), rand_pix());
         repeat ($urandom_range(0, 3)) tick();
      end
      drain(0);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
